// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - command FIFO feeding a LOAD/RUN/NOP sequencer that drives a counter's load/enable/data_in
module counter_ctrl #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [W-1:0]             cmd_arg,
  input  logic                     abort,
  output logic                     load,
  output logic [W-1:0]             data_in,
  output logic                     enable,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]     LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [W-1:0]    CNT_ONE  = W'(1);
  localparam logic [1:0]      OP_LOAD  = 2'b01;
  localparam logic [1:0]      OP_RUN   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_NOP} state_t;

  logic [W+1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_cnt;
  logic [W-1:0]  w_cnt_nxt;
  logic          r_load;
  logic          r_enable;
  logic [W-1:0]  r_data_in;
  logic          w_load_nxt;
  logic          w_enable_nxt;
  logic [W-1:0]  w_data_nxt;

  logic          w_push;
  logic          w_pop;
  logic          w_last;
  logic [1:0]    w_head_op;
  logic [W-1:0]  w_head_arg;

  assign cmd_ready              = (r_level < LVL_FULL);
  assign w_push                 = cmd_valid && cmd_ready && !abort;
  assign {w_head_op, w_head_arg} = r_mem[r_rd_ptr];

  // IDLE counts as "last cycle" so a waiting command pops without an extra bubble
  assign w_last = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_NOP) ||
                  ((r_state == S_RUN) && (r_cnt <= CNT_ONE));
  assign w_pop  = w_last && (r_level != '0) && !abort;

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= {cmd_op, cmd_arg};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_load    <= 1'b0;
      r_enable  <= 1'b0;
      r_data_in <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_load    <= w_load_nxt;
      r_enable  <= w_enable_nxt;
      r_data_in <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (w_pop) begin
      case (w_head_op)
        OP_LOAD: w_state_nxt = S_LOAD;
        OP_RUN: begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = w_head_arg;
        end
        default: w_state_nxt = S_NOP;
      endcase
    end else if (w_last) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (r_state == S_RUN) begin
      w_cnt_nxt = r_cnt - CNT_ONE;
    end
  end

  // Outputs are computed from the next state so they can be registered with no extra latency
  always_comb begin
    w_load_nxt   = (w_state_nxt == S_LOAD);
    w_enable_nxt = (w_state_nxt == S_RUN) && (w_cnt_nxt != '0);
    w_data_nxt   = r_data_in;
    if (w_pop && (w_head_op == OP_LOAD)) begin
      w_data_nxt = w_head_arg;
    end
  end

  assign load    = r_load;
  assign enable  = r_enable;
  assign data_in = r_data_in;
  assign busy    = (r_state != S_IDLE) || (r_level != '0);
  assign level   = r_level;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - directed bench for counter_ctrl with an output-event scoreboard
module tb_counter_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       abort;
  logic       load;
  logic [7:0] data_in;
  logic       enable;
  logic       busy;
  logic [2:0] level;

  int         total;
  int         bad;
  bit         mon_en;
  logic [9:0] sb_q[$];
  logic [7:0] exp_data;
  logic [7:0] ds;
  int         waited;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;

  counter_ctrl #(.DEPTH(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .abort     (abort),
    .load      (load),
    .data_in   (data_in),
    .enable    (enable),
    .busy      (busy),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downstream counter driven by the controller's outputs
  always @(posedge clk) begin
    if (!rst_n)      ds <= 8'h00;
    else if (load)   ds <= data_in;
    else if (enable) ds <= ds + 8'h01;
  end

  // every active output cycle must match the next expected event, in order
  always @(negedge clk) begin
    logic [9:0] obs;
    logic [9:0] exp;
    if (mon_en && (load || enable)) begin
      obs = {load, enable, data_in};
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 10'h3FF;
      total++;
      assert (obs === exp) else begin
        bad++;
        $error("FAIL sb_event obs=%h exp=%h", obs, exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] arg, output int n);
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    while (!cmd_ready && n < 100) begin
      cyc();
      n++;
    end
    chk("send_ready", {31'd0, cmd_ready}, 32'd1);
    if (op == OP_LOAD) begin
      sb_q.push_back({1'b1, 1'b0, arg});
      exp_data = arg;
    end else if (op == OP_RUN) begin
      for (int i = 0; i < arg; i++) sb_q.push_back({1'b0, 1'b1, exp_data});
    end
    cyc();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    mon_en    = 1'b0;
    exp_data  = 8'h00;
    rst_n     = 1'b0;
    abort     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_arg   = 8'hAA;

    // reset with a command presented: nothing is accepted
    repeat (3) cyc();
    chk("rst_level", level, 0);
    chk("rst_load", load, 0);
    chk("rst_enable", enable, 0);
    chk("rst_data", data_in, 0);
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    mon_en    = 1'b1;
    cyc();
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_level", level, 0);

    // single LOAD: strobe two cycles after acceptance, busy drops after
    send(OP_LOAD, 8'hDE, waited);
    chk("ld_level1", level, 1);
    chk("ld_early", load, 0);
    chk("ld_busy", busy, 1);
    cyc();
    chk("ld_strobe", load, 1);
    chk("ld_data", data_in, 8'hDE);
    chk("ld_enable", enable, 0);
    chk("ld_level0", level, 0);
    cyc();
    chk("ld_done", load, 0);
    chk("ld_idle_busy", busy, 0);
    chk("ld_hold", data_in, 8'hDE);

    // LOAD 0x10 then RUN 5 back-to-back
    send(OP_LOAD, 8'h10, waited);
    send(OP_RUN, 8'd5, waited);
    chk("lr_load", load, 1);
    chk("lr_data", data_in, 8'h10);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("lr_enable_on", enable, 1);
      chk("lr_load_off", load, 0);
    end
    cyc();
    chk("lr_enable_off", enable, 0);
    chk("lr_counter", ds, 8'h15);
    chk("lr_busy", busy, 0);

    // fill FIFO behind a running RUN 10
    send(OP_RUN, 8'd10, waited);
    send(OP_RUN, 8'd20, waited);
    send(OP_LOAD, 8'h40, waited);
    send(OP_RUN, 8'd2, waited);
    send(OP_NOP, 8'h00, waited);
    chk("full_level", level, 4);
    chk("full_ready", cmd_ready, 0);
    chk("full_busy", busy, 1);
    send(OP_LOAD, 8'h55, waited);
    chk("full_wait", waited, 7);
    chk("full_level_after", level, 4);

    // abort on RUN 20 cycle 7
    repeat (5) cyc();
    chk("ab_pre_enable", enable, 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    sb_q.delete();
    exp_data = 8'h10;
    chk("ab_enable", enable, 0);
    chk("ab_load", load, 0);
    chk("ab_level", level, 0);
    chk("ab_busy", busy, 0);
    chk("ab_data", data_in, 8'h10);
    repeat (30) cyc();
    chk("ab_quiet_busy", busy, 0);

    // command handshaked with abort is discarded
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_arg   = 8'h77;
    cyc();
    abort     = 1'b0;
    cmd_valid = 1'b0;
    chk("abh_level", level, 0);
    cyc();
    chk("abh_load", load, 0);
    chk("abh_busy", busy, 0);

    // RUN 0 and NOP each take one idle cycle between loads
    send(OP_LOAD, 8'h01, waited);
    send(OP_RUN, 8'd0, waited);
    chk("gap_load1", load, 1);
    chk("gap_data1", data_in, 8'h01);
    send(OP_NOP, 8'h00, waited);
    chk("gap_run0", {30'd0, load, enable}, 0);
    send(OP_LOAD, 8'h02, waited);
    chk("gap_nop", {30'd0, load, enable}, 0);
    cyc();
    chk("gap_load2", load, 1);
    chk("gap_data2", data_in, 8'h02);
    cyc();
    chk("gap_busy", busy, 0);

    // reset during RUN 10 cycle 4 with a command queued
    send(OP_RUN, 8'd10, waited);
    send(OP_LOAD, 8'h88, waited);
    repeat (3) cyc();
    chk("mr_enable_pre", enable, 1);
    chk("mr_level_pre", level, 1);
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_arg   = 8'h99;
    cyc();
    sb_q.delete();
    exp_data = 8'h00;
    chk("mr_enable", enable, 0);
    chk("mr_load", load, 0);
    chk("mr_data", data_in, 8'h00);
    chk("mr_level", level, 0);
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cyc();
    chk("mr_ready", cmd_ready, 1);
    chk("mr_busy", busy, 0);
    repeat (3) cyc();
    send(OP_LOAD, 8'h33, waited);
    cyc();
    chk("mr_load33", load, 1);
    chk("mr_data33", data_in, 8'h33);
    cyc();
    chk("mr_idle", busy, 0);

    repeat (3) cyc();
    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
